// File: rtl/div_seq_unit_pkg.sv
// Shared types and constants for the div_seq_unit sequential divider.
// Build option: DIV_WORD_SHORT_EN shortens W-form divides to 32 iterations.
package div_seq_unit_pkg;

    localparam int XLEN  = 64;
    localparam int OP_W  = 3;
    localparam int HALF  = XLEN / 2;
    localparam int CNT_W = $clog2(XLEN + 1);

    localparam logic [OP_W-1:0] DIV_DIV   = 3'b000;
    localparam logic [OP_W-1:0] DIV_DIVU  = 3'b001;
    localparam logic [OP_W-1:0] DIV_REM   = 3'b010;
    localparam logic [OP_W-1:0] DIV_REMU  = 3'b011;
    localparam logic [OP_W-1:0] DIV_DIVW  = 3'b100;
    localparam logic [OP_W-1:0] DIV_DIVUW = 3'b101;
    localparam logic [OP_W-1:0] DIV_REMW  = 3'b110;
    localparam logic [OP_W-1:0] DIV_REMUW = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } div_state_e;

    // Widen a 32-bit value to XLEN by copying its bit 31 upward.
    function automatic logic [XLEN-1:0] sextWord(input logic [HALF-1:0] v);
        return {{HALF{v[HALF-1]}}, v};
    endfunction

endpackage

// File: rtl/div_seq_unit_if.sv
// Request/response bundle between the EXU and the div_seq_unit divider.
interface div_seq_unit_if;
    import div_seq_unit_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] div_op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] div_result;

    modport master (
        output in_valid, div_op, src1, src2, out_ready,
        input  in_ready, out_valid, div_result
    );

    modport slave (
        input  in_valid, div_op, src1, src2, out_ready,
        output in_ready, out_valid, div_result
    );

endinterface

// File: rtl/div_seq_unit_iter_step.sv
// One combinational radix-2 restoring division step.
module div_seq_unit_iter_step
    import div_seq_unit_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0]   w_remShift;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;

    // Shift the next dividend bit into the partial remainder, keeping the carry-out
    // bit so a full-width unsigned divisor still compares correctly.
    always_comb begin
        w_remShift = {i_rem, i_quo[XLEN-1]};
        w_ge       = (w_remShift >= {1'b0, i_divisor});
        w_diff     = w_remShift[XLEN-1:0] - i_divisor;
        o_rem      = w_ge ? w_diff : w_remShift[XLEN-1:0];
        o_quo      = {i_quo[XLEN-2:0], w_ge};
    end

endmodule

// File: rtl/div_seq_unit.sv
// Multi-cycle RV64M divide/remainder sequencer (DIV/DIVU/REM/REMU and W forms).
// Build option: DIV_WORD_SHORT_EN runs W forms on 32-bit magnitudes in 32 steps.
module div_seq_unit
    import div_seq_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    div_seq_unit_if.slave bus
);

    div_state_e       r_state;
    div_state_e       w_nextState;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_divisor;
    logic [XLEN-1:0]  r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_negQ;
    logic             r_negR;
    logic             r_isRem;
    logic             r_isWord;

    logic             w_isUnsigned;
    logic             w_isRem;
    logic             w_isWord;
    logic             w_accept;
    logic             w_divZero;
    logic             w_overflow;
    logic             w_special;
    logic             w_signA;
    logic             w_signB;
    logic [XLEN-1:0]  w_opA;
    logic [XLEN-1:0]  w_opB;
    logic [XLEN-1:0]  w_magA;
    logic [XLEN-1:0]  w_magB;
    logic [XLEN-1:0]  w_loadQuo;
    logic [CNT_W-1:0] w_loadCnt;
    logic [XLEN-1:0]  w_specSel;
    logic [XLEN-1:0]  w_specResult;
    logic [XLEN-1:0]  w_stepRem;
    logic [XLEN-1:0]  w_stepQuo;
    logic [XLEN-1:0]  w_quoFix;
    logic [XLEN-1:0]  w_remFix;
    logic [XLEN-1:0]  w_fixSel;
    logic [XLEN-1:0]  w_fixResult;

    div_seq_unit_iter_step u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_stepRem),
        .o_quo     (w_stepQuo)
    );

    assign bus.in_ready   = (r_state == ST_IDLE);
    assign bus.out_valid  = (r_state == ST_DONE);
    assign bus.div_result = r_result;

    // Decode the incoming op: extend W operands, take magnitudes, spot the
    // divide-by-zero and signed-overflow cases that skip the iteration loop.
    always_comb begin
        w_isUnsigned = bus.div_op[0];
        w_isRem      = bus.div_op[1];
        w_isWord     = bus.div_op[2];
        w_accept     = bus.in_valid & ~flush & (r_state == ST_IDLE);

        if (w_isWord) begin
            w_opA = w_isUnsigned ? {{HALF{1'b0}}, bus.src1[HALF-1:0]} : sextWord(bus.src1[HALF-1:0]);
            w_opB = w_isUnsigned ? {{HALF{1'b0}}, bus.src2[HALF-1:0]} : sextWord(bus.src2[HALF-1:0]);
            w_overflow = ~w_isUnsigned
                       & (bus.src1[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}})
                       & (bus.src2[HALF-1:0] == {HALF{1'b1}});
        end else begin
            w_opA = bus.src1;
            w_opB = bus.src2;
            w_overflow = ~w_isUnsigned
                       & (bus.src1 == {1'b1, {(XLEN-1){1'b0}}})
                       & (bus.src2 == {XLEN{1'b1}});
        end

        w_signA   = ~w_isUnsigned & w_opA[XLEN-1];
        w_signB   = ~w_isUnsigned & w_opB[XLEN-1];
        w_magA    = w_signA ? -w_opA : w_opA;
        w_magB    = w_signB ? -w_opB : w_opB;
        w_divZero = (w_opB == '0);
        w_special = w_divZero | w_overflow;

        w_specSel    = w_isRem ? (w_divZero ? w_opA : '0)
                               : (w_divZero ? {XLEN{1'b1}} : w_opA);
        w_specResult = w_isWord ? sextWord(w_specSel[HALF-1:0]) : w_specSel;

`ifdef DIV_WORD_SHORT_EN
        if (w_isWord) begin
            w_loadQuo = {w_magA[HALF-1:0], {HALF{1'b0}}};
            w_loadCnt = CNT_W'(HALF);
        end else begin
            w_loadQuo = w_magA;
            w_loadCnt = CNT_W'(XLEN);
        end
`else
        w_loadQuo = w_magA;
        w_loadCnt = CNT_W'(XLEN);
`endif
    end

    // Apply recorded signs to the magnitudes and pick the requested half;
    // W forms always sign-extend bit 31, unsigned ones included.
    always_comb begin
        w_quoFix    = r_negQ ? -r_quo : r_quo;
        w_remFix    = r_negR ? -r_rem : r_rem;
        w_fixSel    = r_isRem ? w_remFix : w_quoFix;
        w_fixResult = r_isWord ? sextWord(w_fixSel[HALF-1:0]) : w_fixSel;
    end

    // State register for the IDLE -> CALC -> FIX -> DONE sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; flush overrides every state and blocks acceptance.
    always_comb begin
        w_nextState = r_state;
        if (flush) begin
            w_nextState = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: if (w_accept) w_nextState = w_special ? ST_DONE : ST_CALC;
                ST_CALC: if (r_cnt == CNT_W'(1)) w_nextState = ST_FIX;
                ST_FIX:  w_nextState = ST_DONE;
                ST_DONE: if (bus.out_ready) w_nextState = ST_IDLE;
                default: w_nextState = ST_IDLE;
            endcase
        end
    end

    // Datapath: load operands on accept, iterate in CALC, latch the result in
    // FIX; the result register is left alone in DONE so it stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
            r_cnt     <= '0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_isRem   <= 1'b0;
            r_isWord  <= 1'b0;
        end else if (!flush) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rem     <= '0;
                        r_quo     <= w_loadQuo;
                        r_divisor <= w_magB;
                        r_cnt     <= w_loadCnt;
                        r_negQ    <= w_signA ^ w_signB;
                        r_negR    <= w_signA;
                        r_isRem   <= w_isRem;
                        r_isWord  <= w_isWord;
                        if (w_special) begin
                            r_result <= w_specResult;
                        end
                    end
                end
                ST_CALC: begin
                    r_rem <= w_stepRem;
                    r_quo <= w_stepQuo;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_FIX: begin
                    r_result <= w_fixResult;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_unit.sv
// Scoreboard testbench for div_seq_unit: directed vectors with hand-computed
// results and latencies; a negedge monitor checks every presented result.
module tb_div_seq_unit;
    import div_seq_unit_pkg::*;

`ifdef DIV_WORD_SHORT_EN
    localparam int W_LAT = 34;
`else
    localparam int W_LAT = 66;
`endif
    localparam int N_LAT = 66;
    localparam int S_LAT = 1;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [63:0] result;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    int   total = 0;
    int   bad = 0;
    int   cycleCnt = 0;

    exp_t  expQ[$];
    string nameQ[$];
    exp_t  lastExp;
    string lastName;
    bit    holding = 1'b0;
    bit    holdValid = 1'b0;

    div_seq_unit_if bus ();

    div_seq_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    // Free-running clock and a cycle counter used to measure latency.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Single comparison point: every check goes through here and bumps the counts.
    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Count a bounded wait that ran out as a failed comparison.
    task automatic timeoutFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got=timeout want=event", name);
    endtask

    // Wait (bounded) for in_ready at a negedge and start driving an op.
    task automatic driveOp(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, output bit ok);
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        ok = (bus.in_ready === 1'b1);
        if (ok) begin
            bus.in_valid = 1'b1;
            bus.div_op   = op;
            bus.src1     = a;
            bus.src2     = b;
        end
    endtask

    // Issue one op and push its expected result and latency to the scoreboard.
    task automatic issueOp(input string name, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] want, input int lat);
        exp_t e;
        bit   ok;
        driveOp(op, a, b, ok);
        if (!ok) begin
            timeoutFail({name, "_ready"});
            return;
        end
        e.result = want;
        e.lat    = lat;
        e.acc    = cycleCnt;
        expQ.push_back(e);
        nameQ.push_back(name);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput({name, "_busy"}, {63'b0, bus.in_ready}, 64'd0);
    endtask

    // Bounded wait until the monitor has consumed every expected result.
    task automatic waitDone(input string name);
        int guard;
        guard = 0;
        while (expQ.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (expQ.size() != 0) begin
            timeoutFail({name, "_done"});
            expQ.delete();
            nameQ.delete();
        end
    endtask

    task automatic applyStimulus(input string name, input logic [2:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] want, input int lat);
        issueOp(name, op, a, b, want, lat);
        waitDone(name);
    endtask

    // Monitor: on the first cycle a result is presented, pop and compare value
    // and latency; while it is held, keep comparing against the same entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
            if (!holding) begin
                holding = 1'b1;
                if (expQ.size() == 0) begin
                    holdValid = 1'b0;
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_result: got out_valid=1 result=%h want=no result", bus.div_result);
                end else begin
                    holdValid = 1'b1;
                    lastExp   = expQ.pop_front();
                    lastName  = nameQ.pop_front();
                    checkOutput(lastName, bus.div_result, lastExp.result);
                    checkOutput({lastName, "_lat"}, 64'(cycleCnt - lastExp.acc), 64'(lastExp.lat));
                    checkOutput({lastName, "_inready"}, {63'b0, bus.in_ready}, 64'd0);
                end
            end else if (holdValid) begin
                checkOutput({lastName, "_hold"}, bus.div_result, lastExp.result);
            end
        end else begin
            holding   = 1'b0;
            holdValid = 1'b0;
        end
    end

    // Watchdog so a stuck design still produces a verdict.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got=hang want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin
        bit ok;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.div_op    = 3'b000;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.out_ready = 1'b1;

        #12;
        checkOutput("reset_in_ready", {63'b0, bus.in_ready}, 64'd1);
        checkOutput("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
        checkOutput("reset_result", bus.div_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("divu_100_7", DIV_DIVU, 64'd100, 64'd7, 64'd14, N_LAT);
        applyStimulus("remu_100_7", DIV_REMU, 64'd100, 64'd7, 64'd2, N_LAT);
        applyStimulus("div_m7_2", DIV_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, N_LAT);
        applyStimulus("rem_m7_2", DIV_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, N_LAT);
        applyStimulus("div_7_m2", DIV_DIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, N_LAT);
        applyStimulus("rem_7_m2", DIV_REM, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, N_LAT);
        applyStimulus("divu_max", DIV_DIVU, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, N_LAT);
        applyStimulus("remu_max", DIV_REMU, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, N_LAT);
        applyStimulus("div_5_0", DIV_DIV, 64'd5, 64'd0, ONES, S_LAT);
        applyStimulus("remu_5_0", DIV_REMU, 64'd5, 64'd0, 64'd5, S_LAT);
        applyStimulus("div_ovf", DIV_DIV, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, S_LAT);
        applyStimulus("rem_ovf", DIV_REM, 64'h8000_0000_0000_0000, ONES, 64'd0, S_LAT);
        applyStimulus("divw_ovf", DIV_DIVW, 64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, S_LAT);
        applyStimulus("divuw_ffff_1", DIV_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, ONES, W_LAT);
        applyStimulus("divw_100_m7", DIV_DIVW, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_FFFF_FFF9,
                      64'hFFFF_FFFF_FFFF_FFF2, W_LAT);
        applyStimulus("remw_m7_2", DIV_REMW, 64'hAAAA_AAAA_FFFF_FFF9, 64'd2, ONES, W_LAT);
        applyStimulus("divuw_2g_3", DIV_DIVUW, 64'h0000_0000_8000_0000, 64'd3, 64'h0000_0000_2AAA_AAAA, W_LAT);
        applyStimulus("remuw_f_16", DIV_REMUW, 64'h1234_5678_FFFF_FFFF, 64'd16, 64'd15, W_LAT);

        driveOp(DIV_DIVU, 64'd1000, 64'd3, ok);
        if (!ok) timeoutFail("flush_issue");
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_idle", {63'b0, bus.in_ready}, 64'd1);
        checkOutput("flush_no_valid", {63'b0, bus.out_valid}, 64'd0);
        repeat (80) @(negedge clk);
        checkOutput("flush_quiet", {63'b0, bus.out_valid}, 64'd0);
        applyStimulus("divu_9_3", DIV_DIVU, 64'd9, 64'd3, 64'd3, N_LAT);

        bus.in_valid = 1'b1;
        bus.div_op   = DIV_DIV;
        bus.src1     = 64'd5;
        bus.src2     = 64'd0;
        flush        = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        checkOutput("flush_noaccept", {63'b0, bus.in_ready}, 64'd1);
        repeat (3) @(negedge clk);

        bus.out_ready = 1'b0;
        issueOp("hold_divu", DIV_DIVU, 64'd100, 64'd7, 64'd14, N_LAT);
        begin
            int guard;
            guard = 0;
            while (bus.out_valid !== 1'b1 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (bus.out_valid !== 1'b1) timeoutFail("hold_valid");
        end
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("hold_release", {63'b0, bus.out_valid}, 64'd0);
        checkOutput("hold_idle", {63'b0, bus.in_ready}, 64'd1);
        waitDone("hold_divu");

        driveOp(DIV_DIVU, 64'd1000, 64'd3, ok);
        if (!ok) timeoutFail("reset_issue");
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_in_ready", {63'b0, bus.in_ready}, 64'd1);
        checkOutput("midreset_out_valid", {63'b0, bus.out_valid}, 64'd0);
        checkOutput("midreset_result", bus.div_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        checkOutput("midreset_quiet", {63'b0, bus.out_valid}, 64'd0);
        applyStimulus("after_reset", DIV_REMU, 64'd100, 64'd7, 64'd2, N_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
